axil_arb2: RTL and testbench

AXIL_ARB2 -- requirements
Module: axil_arb2

---
 rtl/axil_arb2.sv | 246 ++++++++++++++++++++++++
 tb/tb_axil_arb2.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_arb2.sv
// axil_arb2: two-requester AXI-lite arbiter feeding one downstream AXI-lite port.
// Only one transaction (write or read) is outstanding downstream at a time; the
// grant is registered, so a request sampled in IDLE reaches s_* on the next cycle.
module axil_arb2 #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // requester 0
  input  logic        m0_awvalid,
  input  logic [31:0] m0_awaddr,
  input  logic [2:0]  m0_awprot,
  output logic        m0_awready,
  input  logic        m0_wvalid,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_wready,
  output logic        m0_bvalid,
  input  logic        m0_bready,
  input  logic        m0_arvalid,
  input  logic [31:0] m0_araddr,
  input  logic [2:0]  m0_arprot,
  output logic        m0_arready,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m0_rready,
  // requester 1
  input  logic        m1_awvalid,
  input  logic [31:0] m1_awaddr,
  input  logic [2:0]  m1_awprot,
  output logic        m1_awready,
  input  logic        m1_wvalid,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_wready,
  output logic        m1_bvalid,
  input  logic        m1_bready,
  input  logic        m1_arvalid,
  input  logic [31:0] m1_araddr,
  input  logic [2:0]  m1_arprot,
  output logic        m1_arready,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  input  logic        m1_rready,
  // downstream port
  output logic        s_awvalid,
  output logic [31:0] s_awaddr,
  output logic [2:0]  s_awprot,
  input  logic        s_awready,
  output logic        s_wvalid,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_wready,
  input  logic        s_bvalid,
  output logic        s_bready,
  output logic        s_arvalid,
  output logic [31:0] s_araddr,
  output logic [2:0]  s_arprot,
  input  logic        s_arready,
  input  logic        s_rvalid,
  input  logic [31:0] s_rdata,
  output logic        s_rready,
  // status
  output logic [1:0]  grant_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2
  } state_t;

  state_t state_q, state_d;
  logic   owner_q, owner_d;
  logic   last_q, last_d;
  logic   aw_done_q, aw_done_d;
  logic   w_done_q, w_done_d;
  logic   ar_done_q, ar_done_d;

  // Requester-side inputs gathered into indexable form
  logic [1:0]  awvalid_m, wvalid_m, bready_m, arvalid_m, rready_m;
  logic [31:0] awaddr_m [2];
  logic [2:0]  awprot_m [2];
  logic [31:0] wdata_m  [2];
  logic [3:0]  wstrb_m  [2];
  logic [31:0] araddr_m [2];
  logic [2:0]  arprot_m [2];

  assign awvalid_m = {m1_awvalid, m0_awvalid};
  assign wvalid_m  = {m1_wvalid,  m0_wvalid};
  assign bready_m  = {m1_bready,  m0_bready};
  assign arvalid_m = {m1_arvalid, m0_arvalid};
  assign rready_m  = {m1_rready,  m0_rready};
  assign awaddr_m[0] = m0_awaddr;
  assign awaddr_m[1] = m1_awaddr;
  assign awprot_m[0] = m0_awprot;
  assign awprot_m[1] = m1_awprot;
  assign wdata_m[0]  = m0_wdata;
  assign wdata_m[1]  = m1_wdata;
  assign wstrb_m[0]  = m0_wstrb;
  assign wstrb_m[1]  = m1_wstrb;
  assign araddr_m[0] = m0_araddr;
  assign araddr_m[1] = m1_araddr;
  assign arprot_m[0] = m0_arprot;
  assign arprot_m[1] = m1_arprot;

  // Requester-side outputs produced per requester below
  logic [1:0]  awready_m, wready_m, bvalid_m, arready_m, rvalid_m;
  logic [31:0] rdata_m [2];

  logic in_wr, in_rd;
  logic b_ok;
  logic fwd_bvalid, fwd_rvalid;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
  logic [1:0] req;
  logic win;

  assign in_wr = (state_q == WR);
  assign in_rd = (state_q == RD);

  // The response is only meaningful once both write channels have handshaken;
  // gating bvalid too keeps an early s_bvalid from completing the write upstream.
  assign b_ok       = aw_done_q & w_done_q;
  assign fwd_bvalid = in_wr & b_ok & s_bvalid;
  assign fwd_rvalid = in_rd & ar_done_q & s_rvalid;

  // Downstream drive: owner's channels while in flight, all zero otherwise
  assign s_awvalid = in_wr & awvalid_m[owner_q] & ~aw_done_q;
  assign s_awaddr  = in_wr ? awaddr_m[owner_q] : 32'd0;
  assign s_awprot  = in_wr ? awprot_m[owner_q] : 3'd0;
  assign s_wvalid  = in_wr & wvalid_m[owner_q] & ~w_done_q;
  assign s_wdata   = in_wr ? wdata_m[owner_q] : 32'd0;
  assign s_wstrb   = in_wr ? wstrb_m[owner_q] : 4'd0;
  assign s_bready  = in_wr & b_ok & bready_m[owner_q];
  assign s_arvalid = in_rd & arvalid_m[owner_q] & ~ar_done_q;
  assign s_araddr  = in_rd ? araddr_m[owner_q] : 32'd0;
  assign s_arprot  = in_rd ? arprot_m[owner_q] : 3'd0;
  assign s_rready  = in_rd & ar_done_q & rready_m[owner_q];

  assign aw_hs = s_awvalid & s_awready;
  assign w_hs  = s_wvalid & s_wready;
  assign b_hs  = fwd_bvalid & bready_m[owner_q];
  assign ar_hs = s_arvalid & s_arready;
  assign r_hs  = fwd_rvalid & rready_m[owner_q];

  // Per-requester return path; the non-owner sees everything at zero
  for (genvar gi = 0; gi < 2; gi++) begin : g_req
    logic mine;
    assign mine          = (int'(owner_q) == gi);
    assign awready_m[gi] = mine & in_wr & ~aw_done_q & s_awready;
    assign wready_m[gi]  = mine & in_wr & ~w_done_q & s_wready;
    assign bvalid_m[gi]  = mine & fwd_bvalid;
    assign arready_m[gi] = mine & in_rd & ~ar_done_q & s_arready;
    assign rvalid_m[gi]  = mine & fwd_rvalid;
    assign rdata_m[gi]   = (mine & in_rd) ? s_rdata : 32'd0;
  end

  assign m0_awready = awready_m[0];
  assign m0_wready  = wready_m[0];
  assign m0_bvalid  = bvalid_m[0];
  assign m0_arready = arready_m[0];
  assign m0_rvalid  = rvalid_m[0];
  assign m0_rdata   = rdata_m[0];
  assign m1_awready = awready_m[1];
  assign m1_wready  = wready_m[1];
  assign m1_bvalid  = bvalid_m[1];
  assign m1_arready = arready_m[1];
  assign m1_rvalid  = rvalid_m[1];
  assign m1_rdata   = rdata_m[1];

  assign busy_o  = in_wr | in_rd;
  assign grant_o = busy_o ? (owner_q ? 2'b10 : 2'b01) : 2'b00;

  // Arbitration: a requester asks when either address valid is up
  assign req = awvalid_m | arvalid_m;

  // Winner selection; on a tie round-robin favours whoever was not served last
  always_comb begin
    win = 1'b0;
    if (req == 2'b11) begin
      win = RR_EN ? ~last_q : 1'b0;
    end else begin
      win = req[1];
    end
  end

  // Next-state logic: grant in IDLE, track channel completion, release on B/R
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    aw_done_d = aw_done_q | aw_hs;
    w_done_d  = w_done_q | w_hs;
    ar_done_d = ar_done_q | ar_hs;
    case (state_q)
      IDLE: begin
        aw_done_d = 1'b0;
        w_done_d  = 1'b0;
        ar_done_d = 1'b0;
        if (req != 2'b00) begin
          owner_d = win;
          state_d = awvalid_m[win] ? WR : RD;
        end
      end
      WR: begin
        if (b_hs) begin
          state_d   = IDLE;
          last_d    = owner_q;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      RD: begin
        if (r_hs) begin
          state_d   = IDLE;
          last_d    = owner_q;
          ar_done_d = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register; reset leaves m0 as the winner of the first tie
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      last_q    <= 1'b1;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      ar_done_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      last_q    <= last_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      ar_done_q <= ar_done_d;
    end
  end

endmodule

// File: tb/tb_axil_arb2.sv
// tb_axil_arb2: directed bench for axil_arb2. A round-robin instance and a
// fixed-priority instance share all inputs; a vector table covers read
// contention and hand-written sequences cover write ordering and reset.
module tb_axil_arb2;

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  always #5 clk = ~clk;

  // shared inputs
  logic        m0_awvalid, m0_wvalid, m0_bready, m0_arvalid, m0_rready;
  logic [31:0] m0_awaddr, m0_wdata, m0_araddr;
  logic [2:0]  m0_awprot, m0_arprot;
  logic [3:0]  m0_wstrb;
  logic        m1_awvalid, m1_wvalid, m1_bready, m1_arvalid, m1_rready;
  logic [31:0] m1_awaddr, m1_wdata, m1_araddr;
  logic [2:0]  m1_awprot, m1_arprot;
  logic [3:0]  m1_wstrb;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [31:0] s_rdata;

  // round-robin instance outputs
  logic        m0_awready, m0_wready, m0_bvalid, m0_arready, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_awready, m1_wready, m1_bvalid, m1_arready, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic [31:0] s_awaddr, s_wdata, s_araddr;
  logic [2:0]  s_awprot, s_arprot;
  logic [3:0]  s_wstrb;
  logic [1:0]  grant_o;
  logic        busy_o;

  // fixed-priority instance outputs
  logic        f_m0_awready, f_m0_wready, f_m0_bvalid, f_m0_arready, f_m0_rvalid;
  logic [31:0] f_m0_rdata;
  logic        f_m1_awready, f_m1_wready, f_m1_bvalid, f_m1_arready, f_m1_rvalid;
  logic [31:0] f_m1_rdata;
  logic        f_s_awvalid, f_s_wvalid, f_s_bready, f_s_arvalid, f_s_rready;
  logic [31:0] f_s_awaddr, f_s_wdata, f_s_araddr;
  logic [2:0]  f_s_awprot, f_s_arprot;
  logic [3:0]  f_s_wstrb;
  logic [1:0]  f_grant_o;
  logic        f_busy_o;

  axil_arb2 #(.RR_EN(1'b1)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awready(m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(m0_wready),
    .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arready(m0_arready),
    .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awready(m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(m1_wready),
    .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arready(m1_arready),
    .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rready(m1_rready),
    .s_awvalid(s_awvalid), .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awready(s_awready),
    .s_wvalid(s_wvalid), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(s_rready),
    .grant_o(grant_o), .busy_o(busy_o)
  );

  axil_arb2 #(.RR_EN(1'b0)) dut_f (
    .clk_i(clk), .rst_i(rst_i),
    .m0_awvalid(m0_awvalid), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot), .m0_awready(f_m0_awready),
    .m0_wvalid(m0_wvalid), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb), .m0_wready(f_m0_wready),
    .m0_bvalid(f_m0_bvalid), .m0_bready(m0_bready),
    .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot), .m0_arready(f_m0_arready),
    .m0_rvalid(f_m0_rvalid), .m0_rdata(f_m0_rdata), .m0_rready(m0_rready),
    .m1_awvalid(m1_awvalid), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot), .m1_awready(f_m1_awready),
    .m1_wvalid(m1_wvalid), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb), .m1_wready(f_m1_wready),
    .m1_bvalid(f_m1_bvalid), .m1_bready(m1_bready),
    .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot), .m1_arready(f_m1_arready),
    .m1_rvalid(f_m1_rvalid), .m1_rdata(f_m1_rdata), .m1_rready(m1_rready),
    .s_awvalid(f_s_awvalid), .s_awaddr(f_s_awaddr), .s_awprot(f_s_awprot), .s_awready(s_awready),
    .s_wvalid(f_s_wvalid), .s_wdata(f_s_wdata), .s_wstrb(f_s_wstrb), .s_wready(s_wready),
    .s_bvalid(s_bvalid), .s_bready(f_s_bready),
    .s_arvalid(f_s_arvalid), .s_araddr(f_s_araddr), .s_arprot(f_s_arprot), .s_arready(s_arready),
    .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rready(f_s_rready),
    .grant_o(f_grant_o), .busy_o(f_busy_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    m0_awvalid = 0; m0_awaddr = 0; m0_awprot = 0; m0_wvalid = 0; m0_wdata = 0; m0_wstrb = 0;
    m0_bready = 0; m0_arvalid = 0; m0_araddr = 0; m0_arprot = 0; m0_rready = 0;
    m1_awvalid = 0; m1_awaddr = 0; m1_awprot = 0; m1_wvalid = 0; m1_wdata = 0; m1_wstrb = 0;
    m1_bready = 0; m1_arvalid = 0; m1_araddr = 0; m1_arprot = 0; m1_rready = 0;
    s_awready = 0; s_wready = 0; s_bvalid = 0; s_arready = 0; s_rvalid = 0; s_rdata = 0;
  endtask

  // Leaves the bench at a falling edge with reset released and both DUTs idle
  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    idle_inputs();
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;
  endtask

  typedef struct {
    logic       m0_arv;
    logic       m1_arv;
    logic [1:0] g_rr;
    logic [1:0] g_fx;
    logic       m0_rv;
    logic       m1_rv;
    logic       s_arv;
  } vec_t;

  vec_t tbl [11];
  localparam logic [31:0] RDATA = 32'h1234_5678;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int pulses;

    // Read contention with an always-ready downstream; 3-cycle period per read
    tbl[0]  = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[2]  = '{1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b1, 1'b1, 2'b10, 2'b01, 1'b0, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 2'b01, 2'b01, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 1'b1, 2'b01, 2'b01, 1'b1, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b1};

    idle_inputs();
    do_reset();

    // Reset state
    #1;
    chk("rst_grant", 32'(grant_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_s_awvalid", 32'(s_awvalid), 32'd0);
    chk("rst_s_arvalid", 32'(s_arvalid), 32'd0);
    chk("rst_s_bready", 32'(s_bready), 32'd0);
    chk("rst_s_rready", 32'(s_rready), 32'd0);
    chk("rst_f_grant", 32'(f_grant_o), 32'd0);
    $display("reset: grant=%b busy=%b", grant_o, busy_o);

    // Table: contention, round-robin vs fixed priority
    m0_rready = 1; m1_rready = 1; s_arready = 1; s_rvalid = 1; s_rdata = RDATA;
    m0_araddr = 32'h0000_0100; m1_araddr = 32'h0000_0200;
    for (int i = 0; i < 11; i++) begin
      m0_arvalid = tbl[i].m0_arv;
      m1_arvalid = tbl[i].m1_arv;
      #1;
      chk($sformatf("tbl%0d_grant_rr", i), 32'(grant_o), 32'(tbl[i].g_rr));
      chk($sformatf("tbl%0d_grant_fx", i), 32'(f_grant_o), 32'(tbl[i].g_fx));
      chk($sformatf("tbl%0d_busy_rr", i), 32'(busy_o), 32'(tbl[i].g_rr != 2'b00));
      chk($sformatf("tbl%0d_m0_rvalid", i), 32'(m0_rvalid), 32'(tbl[i].m0_rv));
      chk($sformatf("tbl%0d_m1_rvalid", i), 32'(m1_rvalid), 32'(tbl[i].m1_rv));
      chk($sformatf("tbl%0d_s_arvalid", i), 32'(s_arvalid), 32'(tbl[i].s_arv));
      if (tbl[i].m0_rv) chk($sformatf("tbl%0d_m0_rdata", i), m0_rdata, RDATA);
      if (tbl[i].g_rr == 2'b01) chk($sformatf("tbl%0d_m1_rdata", i), m1_rdata, 32'd0);
      $display("row %0d: grant_rr=%b grant_fx=%b m0_rv=%b m1_rv=%b", i, grant_o, f_grant_o, m0_rvalid, m1_rvalid);
      @(negedge clk);
    end

    // m0 write, AW and W together
    do_reset();
    m0_awvalid = 1; m0_awaddr = 32'h0300_3000; m0_awprot = 3'b010;
    m0_wvalid = 1; m0_wdata = 32'hA5A5_0001; m0_wstrb = 4'hF; m0_bready = 1;
    s_awready = 1; s_wready = 1;
    #1;
    chk("wr0_c0_s_awvalid", 32'(s_awvalid), 32'd0);
    chk("wr0_c0_grant", 32'(grant_o), 32'd0);
    @(negedge clk); #1;
    chk("wr0_c1_s_awvalid", 32'(s_awvalid), 32'd1);
    chk("wr0_c1_s_awaddr", s_awaddr, 32'h0300_3000);
    chk("wr0_c1_s_awprot", 32'(s_awprot), 32'd2);
    chk("wr0_c1_s_wvalid", 32'(s_wvalid), 32'd1);
    chk("wr0_c1_s_wdata", s_wdata, 32'hA5A5_0001);
    chk("wr0_c1_s_wstrb", 32'(s_wstrb), 32'hF);
    chk("wr0_c1_m0_awready", 32'(m0_awready), 32'd1);
    chk("wr0_c1_m0_wready", 32'(m0_wready), 32'd1);
    chk("wr0_c1_m1_awready", 32'(m1_awready), 32'd0);
    chk("wr0_c1_s_bready", 32'(s_bready), 32'd0);
    chk("wr0_c1_grant", 32'(grant_o), 32'b01);
    @(negedge clk);
    m0_awvalid = 0; m0_wvalid = 0; s_bvalid = 1;
    #1;
    chk("wr0_c2_m0_bvalid", 32'(m0_bvalid), 32'd1);
    chk("wr0_c2_m1_bvalid", 32'(m1_bvalid), 32'd0);
    chk("wr0_c2_s_bready", 32'(s_bready), 32'd1);
    chk("wr0_c2_s_awvalid", 32'(s_awvalid), 32'd0);
    @(negedge clk);
    s_bvalid = 0;
    #1;
    chk("wr0_c3_grant", 32'(grant_o), 32'd0);
    chk("wr0_c3_busy", 32'(busy_o), 32'd0);
    chk("wr0_c3_s_awaddr", s_awaddr, 32'd0);
    chk("wr0_c3_m0_bvalid", 32'(m0_bvalid), 32'd0);
    $display("seq wr0: m0 write 0x03003000 complete");

    // m1 write, W three cycles after AW, AW reasserted while in flight
    do_reset();
    pulses = 0;
    m1_awvalid = 1; m1_awaddr = 32'h1000_0004; m1_bready = 1;
    s_awready = 1; s_wready = 1;
    #1;
    if (m1_awready) pulses++;
    @(negedge clk); #1;
    if (m1_awready) pulses++;
    chk("wr1_c1_m1_awready", 32'(m1_awready), 32'd1);
    chk("wr1_c1_s_awvalid", 32'(s_awvalid), 32'd1);
    chk("wr1_c1_grant", 32'(grant_o), 32'b10);
    chk("wr1_c1_m0_awready", 32'(m0_awready), 32'd0);
    @(negedge clk);
    m1_awaddr = 32'h1000_0008; s_bvalid = 1;
    for (int c = 2; c < 4; c++) begin
      #1;
      if (m1_awready) pulses++;
      chk($sformatf("wr1_c%0d_s_awvalid", c), 32'(s_awvalid), 32'd0);
      chk($sformatf("wr1_c%0d_s_bready", c), 32'(s_bready), 32'd0);
      chk($sformatf("wr1_c%0d_m1_bvalid", c), 32'(m1_bvalid), 32'd0);
      @(negedge clk);
    end
    m1_wvalid = 1; m1_wdata = 32'hDEAD_BEEF; m1_wstrb = 4'h3; s_bvalid = 0;
    #1;
    if (m1_awready) pulses++;
    chk("wr1_c4_s_wvalid", 32'(s_wvalid), 32'd1);
    chk("wr1_c4_m1_wready", 32'(m1_wready), 32'd1);
    chk("wr1_c4_s_wdata", s_wdata, 32'hDEAD_BEEF);
    chk("wr1_c4_s_wstrb", 32'(s_wstrb), 32'h3);
    chk("wr1_c4_s_bready", 32'(s_bready), 32'd0);
    @(negedge clk);
    m1_wvalid = 0; s_bvalid = 1;
    #1;
    if (m1_awready) pulses++;
    chk("wr1_c5_m1_bvalid", 32'(m1_bvalid), 32'd1);
    chk("wr1_c5_s_bready", 32'(s_bready), 32'd1);
    chk("wr1_awready_pulses", 32'(pulses), 32'd1);
    @(negedge clk);
    s_bvalid = 0;
    #1;
    chk("wr1_c6_grant", 32'(grant_o), 32'd0);
    @(negedge clk); #1;
    chk("wr1_c7_grant", 32'(grant_o), 32'b10);
    chk("wr1_c7_s_awaddr", s_awaddr, 32'h1000_0008);
    chk("wr1_c7_s_awvalid", 32'(s_awvalid), 32'd1);
    $display("seq wr1: m1 write with late W, second AW granted after B");

    // m0 with both AW and AR: write first, then read
    do_reset();
    m0_awvalid = 1; m0_wvalid = 1; m0_arvalid = 1; m0_araddr = 32'h2000_0010;
    m0_bready = 1; m0_rready = 1;
    s_awready = 1; s_wready = 1; s_arready = 1;
    @(negedge clk); #1;
    chk("wrd_c1_s_awvalid", 32'(s_awvalid), 32'd1);
    chk("wrd_c1_s_arvalid", 32'(s_arvalid), 32'd0);
    chk("wrd_c1_grant", 32'(grant_o), 32'b01);
    @(negedge clk);
    m0_awvalid = 0; m0_wvalid = 0; s_bvalid = 1;
    #1;
    chk("wrd_c2_m0_bvalid", 32'(m0_bvalid), 32'd1);
    chk("wrd_c2_m0_arready", 32'(m0_arready), 32'd0);
    @(negedge clk);
    s_bvalid = 0;
    #1;
    chk("wrd_c3_s_arvalid", 32'(s_arvalid), 32'd0);
    chk("wrd_c3_busy", 32'(busy_o), 32'd0);
    @(negedge clk); #1;
    chk("wrd_c4_s_arvalid", 32'(s_arvalid), 32'd1);
    chk("wrd_c4_s_araddr", s_araddr, 32'h2000_0010);
    chk("wrd_c4_m0_arready", 32'(m0_arready), 32'd1);
    chk("wrd_c4_grant", 32'(grant_o), 32'b01);
    $display("seq wrd: m0 write then read");

    // Reset in the middle of a read, then a late downstream R
    do_reset();
    m0_arvalid = 1; m0_rready = 1; s_arready = 1;
    @(negedge clk); #1;
    chk("rst_rd_c1_s_arvalid", 32'(s_arvalid), 32'd1);
    @(negedge clk);
    m0_arvalid = 0;
    #1;
    chk("rst_rd_c2_busy", 32'(busy_o), 32'd1);
    rst_i = 1'b1;
    @(negedge clk);
    rst_i = 1'b0; s_rvalid = 1; s_rdata = 32'hCAFE_0000;
    for (int c = 3; c < 5; c++) begin
      #1;
      chk($sformatf("rst_rd_c%0d_m0_rvalid", c), 32'(m0_rvalid), 32'd0);
      chk($sformatf("rst_rd_c%0d_busy", c), 32'(busy_o), 32'd0);
      chk($sformatf("rst_rd_c%0d_grant", c), 32'(grant_o), 32'd0);
      chk($sformatf("rst_rd_c%0d_s_rready", c), 32'(s_rready), 32'd0);
      chk($sformatf("rst_rd_c%0d_m0_rdata", c), m0_rdata, 32'd0);
      @(negedge clk);
    end
    $display("seq rst_rd: read abandoned by reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
